multi_clk_divider: RTL

//  Parametrised N-channel clock-enable/tick generator driven from the 100 MHz board clock.
//  - Each channel has a runtime-programmable half-period and produces:
//    - a 50%-duty square output;
//    - a one-cycle tick on each rising edge of that output.
//  - Replaces the fixed single-output 1 Hz divider; feeds LED blink, display refresh and debounce timing.

---
 rtl/multi_clk_divider_pkg.sv | 22 ++
 rtl/multi_clk_divider_channel.sv | 74 +++++++
 rtl/multi_clk_divider.sv | 51 +++++
 3 files changed

// File: rtl/multi_clk_divider_pkg.sv
// Shared definitions for the multi-channel clock-enable / tick generator:
// channel-index width, channel limit, common 100 MHz half-periods and the
// per-channel action encoding.
package multi_clk_divider_pkg;

  localparam int CH_IDX_W = 4;
  localparam int MAX_CH   = 16;

  // Half-period values H for a 100 MHz clock (period = 2*(H+1) clocks)
  localparam int HALF_1HZ  = 49_999_999;
  localparam int HALF_10HZ = 4_999_999;
  localparam int HALF_1KHZ = 49_999;

  // What a channel does on the coming clock edge, highest priority first
  typedef enum logic [1:0] {
    CH_SYNC     = 2'd0,
    CH_DISABLED = 2'd1,
    CH_WRAP     = 2'd2,
    CH_COUNT    = 2'd3
  } ch_act_e;

endpackage

// File: rtl/multi_clk_divider_channel.sv
// One divider channel: counter, active/pending half-period, square output
// and rising-edge tick. New half-periods are staged in pending_half and only
// become active at a wrap, a sync or while disabled, so no runt pulses occur.
module div_channel
  import multi_clk_divider_pkg::*;
#(
  parameter int CNT_W        = 26,
  parameter int DEFAULT_HALF = HALF_1HZ
) (
  input  logic             clk_100MHz,
  input  logic             reset,
  input  logic             ch_en,
  input  logic             sync,
  input  logic             wr_en,
  input  logic [CNT_W-1:0] wr_half,
  output logic             clk_out,
  output logic             tick
);

  localparam logic [CNT_W-1:0] DEF_H = CNT_W'(DEFAULT_HALF);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] active_half;
  logic [CNT_W-1:0] pending_half;
  logic [CNT_W-1:0] pend_nxt;
  ch_act_e          act;

  // Select this cycle's action and the pending value including a same-cycle write
  always_comb begin
    pend_nxt = wr_en ? wr_half : pending_half;
    act      = CH_COUNT;
    if (sync)                     act = CH_SYNC;
    else if (!ch_en)              act = CH_DISABLED;
    else if (cnt == active_half)  act = CH_WRAP;
  end

  // Counter, half-period registers and registered outputs
  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      cnt          <= '0;
      clk_out      <= 1'b0;
      tick         <= 1'b0;
      active_half  <= DEF_H;
      pending_half <= DEF_H;
    end else begin
      pending_half <= pend_nxt;
      case (act)
        CH_SYNC: begin
          cnt         <= '0;
          clk_out     <= 1'b0;
          tick        <= 1'b0;
          active_half <= pend_nxt;
        end
        CH_DISABLED: begin
          cnt         <= '0;
          clk_out     <= 1'b0;
          tick        <= 1'b0;
          active_half <= pending_half;
        end
        CH_WRAP: begin
          cnt         <= '0;
          clk_out     <= ~clk_out;
          tick        <= ~clk_out;
          active_half <= pending_half;
        end
        default: begin
          cnt  <= cnt + 1'b1;
          tick <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/multi_clk_divider.sv
// N-channel clock-enable / tick generator on the 100 MHz board clock.
// Decodes configuration writes to one channel and replicates div_channel.
module multi_clk_divider
  import multi_clk_divider_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int CNT_W        = 26,
  parameter int DEFAULT_HALF = HALF_1HZ
) (
  input  logic                clk_100MHz,
  input  logic                reset,
  input  logic [NUM_CH-1:0]   ch_en,
  input  logic                sync,
  input  logic                wr_en,
  input  logic [CH_IDX_W-1:0] wr_ch,
  input  logic [CNT_W-1:0]    wr_half,
  output logic [NUM_CH-1:0]   clk_out,
  output logic [NUM_CH-1:0]   tick
);

  if (NUM_CH < 1 || NUM_CH > MAX_CH) begin : g_bad_num_ch
    $error("multi_clk_divider: NUM_CH must be in 1..16");
  end

  logic [NUM_CH-1:0] wr_sel;

  // One-hot write select; indices beyond the last channel select nothing
  always_comb begin
    wr_sel = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      wr_sel[i] = wr_en && (int'(wr_ch) == i);
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    div_channel #(
      .CNT_W        (CNT_W),
      .DEFAULT_HALF (DEFAULT_HALF)
    ) u_ch (
      .clk_100MHz (clk_100MHz),
      .reset      (reset),
      .ch_en      (ch_en[g]),
      .sync       (sync),
      .wr_en      (wr_sel[g]),
      .wr_half    (wr_half),
      .clk_out    (clk_out[g]),
      .tick       (tick[g])
    );
  end

endmodule
